audio_sdd_out: RTL and testbench

Fabric-side, parametrised successor to the single MSS sigma-delta DAC output (SDD_1). It accepts multi-channel PCM audio frames over a valid/ready stream and buffers them in a frame FIFO. It pops one frame per programmable sample-rate tick and drives one first-order sigma-delta bitstream per channel to the analog filter pins. The block adds buffering, channel count, mute, priming and underrun reporting.

---
 rtl/audio_sdd_pkg.sv | 28 ++
 rtl/audio_sdd_ch.sv | 57 +++++
 rtl/audio_sdd_out.sv | 191 +++++++++++++++++++
 tb/tb_audio_sdd_out.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_sdd_pkg.sv
// Shared definitions for the fabric sigma-delta audio output block.
package audio_sdd_pkg;

  // Playback controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } sdd_state_e;

  // Offset that maps a two's complement sample onto the unsigned modulator range
  function automatic logic [31:0] MIDSCALE(input int width);
    return 32'd1 << (width - 1);
  endfunction

  // Ceiling log2, used to size pointers and the level counter
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/audio_sdd_ch.sv
// One audio channel: held sample, offset conversion, mute, first-order
// sigma-delta accumulator and the registered bitstream output.
module audio_sdd_ch
  import audio_sdd_pkg::*;
#(
  parameter int SAMPLE_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                load,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                mute,
  output logic                sdd
);

  localparam logic [SAMPLE_W-1:0] MID = SAMPLE_W'(MIDSCALE(SAMPLE_W));

  logic [SAMPLE_W-1:0] held_r;
  logic [SAMPLE_W-1:0] acc_r;
  logic                sdd_r;
  logic [SAMPLE_W-1:0] u_s;
  logic [SAMPLE_W:0]   sum_s;

  // Offset-binary modulator input; mute forces exact 50% density
  always_comb begin
    u_s = MID;
    if (mute) begin
      u_s = MID;
    end else begin
      u_s = held_r ^ MID;
    end
    sum_s = {1'b0, acc_r} + {1'b0, u_s};
  end

  // Held sample, accumulator and carry-out flop; all cleared while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_r <= '0;
      acc_r  <= '0;
      sdd_r  <= 1'b0;
    end else if (clr) begin
      held_r <= '0;
      acc_r  <= '0;
      sdd_r  <= 1'b0;
    end else begin
      if (load) begin
        held_r <= sample;
      end
      acc_r <= sum_s[SAMPLE_W-1:0];
      sdd_r <= sum_s[SAMPLE_W];
    end
  end

  assign sdd = sdd_r;

endmodule

// File: rtl/audio_sdd_out.sv
// Multi-channel sigma-delta audio output: frame FIFO, sample-rate tick,
// IDLE/PRIME/RUN playback controller and per-channel modulators.
module audio_sdd_out
  import audio_sdd_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int SAMPLE_W    = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int PRIME_LEVEL = 2,
  parameter int DIV_W       = 16
) (
  input  logic                               FAB_CLK,
  input  logic                               M2F_RESET_N,
  input  logic                               ENABLE,
  input  logic                               MUTE,
  input  logic [DIV_W-1:0]                   SR_DIV,
  input  logic                               S_VALID,
  input  logic [CHANNELS*SAMPLE_W-1:0]       S_DATA,
  output logic                               S_READY,
  output logic [CHANNELS-1:0]                SDD,
  output logic [clog2(FIFO_DEPTH+1)-1:0]     FIFO_LEVEL,
  output logic                               UNDERRUN,
  input  logic                               UNDERRUN_CLR,
  output logic                               RUNNING
);

  localparam int PTR_W   = clog2(FIFO_DEPTH);
  localparam int LVL_W   = clog2(FIFO_DEPTH + 1);
  localparam int FRAME_W = CHANNELS * SAMPLE_W;

  sdd_state_e         state_r;
  sdd_state_e         state_nxt_s;

  logic [FRAME_W-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [LVL_W-1:0]   level_r;
  logic [LVL_W-1:0]   level_nxt_s;
  logic               ready_r;
  logic               ready_nxt_s;
  logic               underrun_r;
  logic               running_r;
  logic               running_nxt_s;
  logic [DIV_W-1:0]   cnt_r;
  logic [DIV_W-1:0]   div_r;

  logic               push_s;
  logic               empty_s;
  logic               start_s;
  logic               tick_s;
  logic               pop_s;
  logic               urun_set_s;
  logic               ch_clr_s;
  logic [FRAME_W-1:0] head_s;
  logic [CHANNELS-1:0] sdd_s;

  assign push_s     = S_VALID & ready_r;
  assign empty_s    = (level_r == {LVL_W{1'b0}});
  assign start_s    = (state_r == ST_PRIME) && ENABLE && (level_r >= LVL_W'(PRIME_LEVEL));
  assign tick_s     = (state_r == ST_RUN) && ENABLE && (cnt_r == div_r);
  assign pop_s      = (start_s || tick_s) && !empty_s;
  assign urun_set_s = tick_s && empty_s;
  assign head_s     = mem_r[rd_ptr_r];

  // Controller state register
  always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
    if (!M2F_RESET_N) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state: dropping ENABLE always returns to IDLE
  always_comb begin
    state_nxt_s = state_r;
    if (!ENABLE) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:  state_nxt_s = ST_PRIME;
        ST_PRIME: begin
          if (start_s) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_PRIME;
          end
        end
        ST_RUN:   state_nxt_s = ST_RUN;
        default:  state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Controller outputs and next values of the registered status flags
  always_comb begin
    running_nxt_s = (state_nxt_s == ST_RUN);
    ready_nxt_s   = (level_nxt_s != LVL_W'(FIFO_DEPTH));
    ch_clr_s      = !ENABLE || (state_r == ST_IDLE);
  end

  // FIFO occupancy after this cycle's push and pop
  always_comb begin
    level_nxt_s = level_r;
    case ({push_s, pop_s})
      2'b10:   level_nxt_s = level_r + LVL_W'(1'b1);
      2'b01:   level_nxt_s = level_r - LVL_W'(1'b1);
      default: level_nxt_s = level_r;
    endcase
  end

  // Frame storage; contents need no reset since level gates every read
  always_ff @(posedge FAB_CLK) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= S_DATA;
    end
  end

  // FIFO pointers, level and the registered ready flag
  always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
    if (!M2F_RESET_N) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
      ready_r  <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      level_r <= level_nxt_s;
      ready_r <= ready_nxt_s;
    end
  end

  // Sample-rate counter; the period is re-latched at start and every tick
  always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
    if (!M2F_RESET_N) begin
      cnt_r <= '0;
      div_r <= '0;
    end else if (start_s || tick_s) begin
      cnt_r <= '0;
      div_r <= SR_DIV;
    end else if (state_r == ST_RUN) begin
      cnt_r <= cnt_r + DIV_W'(1'b1);
    end
  end

  // Sticky underrun flag; a new event beats a simultaneous clear
  always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
    if (!M2F_RESET_N) begin
      underrun_r <= 1'b0;
    end else if (urun_set_s) begin
      underrun_r <= 1'b1;
    end else if (UNDERRUN_CLR) begin
      underrun_r <= 1'b0;
    end
  end

  // Registered RUN indication
  always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
    if (!M2F_RESET_N) begin
      running_r <= 1'b0;
    end else begin
      running_r <= running_nxt_s;
    end
  end

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    audio_sdd_ch #(
      .SAMPLE_W (SAMPLE_W)
    ) u_ch (
      .clk    (FAB_CLK),
      .rst_n  (M2F_RESET_N),
      .clr    (ch_clr_s),
      .load   (pop_s),
      .sample (head_s[ch*SAMPLE_W +: SAMPLE_W]),
      .mute   (MUTE),
      .sdd    (sdd_s[ch])
    );
  end

  assign S_READY    = ready_r;
  assign SDD        = sdd_s;
  assign FIFO_LEVEL = level_r;
  assign UNDERRUN   = underrun_r;
  assign RUNNING    = running_r;

endmodule

// File: tb/tb_audio_sdd_out.sv
// Directed/randomized bench for audio_sdd_out with a density reference model.
module tb_audio_sdd_out;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic        mute = 1'b0;
  logic [15:0] sr_div = 16'd0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = 32'd0;
  logic        s_ready;
  logic [1:0]  sdd;
  logic [3:0]  level;
  logic        underrun;
  logic        urclr = 1'b0;
  logic        running;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int e_run = 0;
  logic [31:0] q[$];

  audio_sdd_out dut (
    .FAB_CLK      (clk),
    .M2F_RESET_N  (rst_n),
    .ENABLE       (en),
    .MUTE         (mute),
    .SR_DIV       (sr_div),
    .S_VALID      (s_valid),
    .S_DATA       (s_data),
    .S_READY      (s_ready),
    .SDD          (sdd),
    .FIFO_LEVEL   (level),
    .UNDERRUN     (underrun),
    .UNDERRUN_CLR (urclr),
    .RUNNING      (running)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Ones expected from a constant sample over n clocks: n * (sample + half range) / 2^16
  function automatic int exp_ones(input logic [31:0] frame, input int ch, input logic m, input int n);
    logic [15:0] s;
    int u;
    s = frame[ch*16 +: 16];
    if (m) u = 32768;
    else   u = int'($signed(s)) + 32768;
    return (u * n) / 65536;
  endfunction

  // Random frame whose density is exactly resolvable over a 256-clock window
  function automatic logic [31:0] rnd_frame();
    logic [7:0] a;
    logic [7:0] b;
    a = 8'($urandom);
    b = 8'($urandom);
    return {b, 8'h00, a, 8'h00};
  endfunction

  task automatic push(input logic [31:0] f);
    s_valid = 1'b1;
    s_data  = f;
    if (s_ready) q.push_back(f);
    step();
    s_valid = 1'b0;
  endtask

  task automatic count_ones(input int n, output int c0, output int c1);
    c0 = 0;
    c1 = 0;
    for (int i = 0; i < n; i++) begin
      step();
      c0 += int'(sdd[0]);
      c1 += int'(sdd[1]);
    end
  endtask

  initial begin
    logic [31:0] f0, f1, f2;
    int c0, c1, acc;

    // Reset state
    #1 rst_n = 1'b0;
    step(); step();
    chk("rst_ready", 32'(s_ready), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_sdd", 32'(sdd), 32'd0);
    rst_n = 1'b1;
    step();
    chk("ready_after_rst", 32'(s_ready), 32'd1);

    // Priming: one frame is not enough, output is 50% density
    sr_div = 16'd99;
    en = 1'b1;
    f0 = rnd_frame();
    push(f0);
    chk("prime_lvl1", 32'(level), 32'(q.size()));
    count_ones(256, c0, c1);
    chk("prime_d0", 32'(c0), 32'd128);
    chk("prime_d1", 32'(c1), 32'd128);
    chk("prime_running", 32'(running), 32'd0);
    f1 = 32'hC000_4000;
    push(f1);
    chk("prime_lvl2", 32'(level), 32'(q.size()));
    step();
    e_run = cyc;
    void'(q.pop_front());
    chk("run_entry", 32'(running), 32'd1);
    chk("run_lvl", 32'(level), 32'(q.size()));
    repeat (99) step();
    chk("pre_tick_lvl", 32'(level), 32'd1);
    step();
    void'(q.pop_front());
    chk("tick_lvl", 32'(level), 32'(q.size()));
    chk("no_underrun", 32'(underrun), 32'd0);

    // Density of a held sample, then sample-and-hold through underruns
    step(); step();
    count_ones(256, c0, c1);
    chk("dens_ch0", 32'(c0), 32'(exp_ones(f1, 0, 1'b0, 256)));
    chk("dens_ch1", 32'(c1), 32'(exp_ones(f1, 1, 1'b0, 256)));
    chk("underrun_set", 32'(underrun), 32'd1);
    mute = 1'b1;
    step(); step();
    count_ones(256, c0, c1);
    chk("mute_ch0", 32'(c0), 32'(exp_ones(f1, 0, 1'b1, 256)));
    chk("mute_ch1", 32'(c1), 32'(exp_ones(f1, 1, 1'b1, 256)));
    mute = 1'b0;

    // Clear on a cycle without a tick
    if (((cyc + 1 - e_run) % 100) == 0) step();
    urclr = 1'b1;
    step();
    urclr = 1'b0;
    chk("underrun_clr", 32'(underrun), 32'd0);

    // Push coinciding with a tick on an empty FIFO
    while (((cyc + 1 - e_run) % 100) != 0) step();
    f2 = rnd_frame();
    push(f2);
    chk("push_tick_urun", 32'(underrun), 32'd1);
    chk("push_tick_lvl", 32'(level), 32'd1);
    do step(); while (((cyc - e_run) % 100) != 0);
    void'(q.pop_front());
    chk("late_pop_lvl", 32'(level), 32'(q.size()));
    step(); step();
    count_ones(256, c0, c1);
    chk("rnd_ch0", 32'(c0), 32'(exp_ones(f2, 0, 1'b0, 256)));
    chk("rnd_ch1", 32'(c1), 32'(exp_ones(f2, 1, 1'b0, 256)));

    // Asynchronous reset in RUN with five frames stored
    while (((cyc - e_run) % 100) != 0) step();
    for (int i = 0; i < 5; i++) push(rnd_frame());
    chk("lvl5", 32'(level), 32'(q.size()));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", 32'(s_ready), 32'd0);
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_underrun", 32'(underrun), 32'd0);
    chk("arst_running", 32'(running), 32'd0);
    chk("arst_sdd", 32'(sdd), 32'd0);
    en = 1'b0;
    q.delete();
    step(); step();
    rst_n = 1'b1;
    step();
    chk("arst_ready_rise", 32'(s_ready), 32'd1);
    chk("arst_level_after", 32'(level), 32'd0);

    // Backpressure: nine offered, eight fit
    acc = 0;
    for (int i = 0; i < 9; i++) begin
      s_valid = 1'b1;
      s_data  = rnd_frame();
      if (s_ready) begin
        acc++;
        q.push_back(s_data);
      end
      step();
    end
    s_valid = 1'b0;
    chk("bp_accepted", 32'(acc), 32'd8);
    chk("bp_level", 32'(level), 32'(q.size()));
    chk("bp_ready", 32'(s_ready), 32'd0);
    sr_div = 16'd0;
    en = 1'b1;
    step();
    chk("bp_prime", 32'(running), 32'd0);
    step();
    void'(q.pop_front());
    chk("bp_run", 32'(running), 32'd1);
    chk("bp_first_pop", 32'(level), 32'(q.size()));
    chk("bp_ready_rise", 32'(s_ready), 32'd1);
    for (int k = 6; k >= 0; k--) begin
      step();
      void'(q.pop_front());
      chk("bp_drain", 32'(level), 32'(k));
    end

    // ENABLE drop keeps FIFO contents; re-enable goes straight to RUN
    sr_div = 16'd99;
    step();
    for (int i = 0; i < 3; i++) push(rnd_frame());
    chk("drop_lvl3", 32'(level), 32'd3);
    en = 1'b0;
    step();
    chk("drop_running", 32'(running), 32'd0);
    chk("drop_sdd", 32'(sdd), 32'd0);
    chk("drop_lvl", 32'(level), 32'd3);
    repeat (3) step();
    chk("idle_sdd", 32'(sdd), 32'd0);
    chk("idle_lvl", 32'(level), 32'd3);
    en = 1'b1;
    step();
    chk("reen_prime", 32'(running), 32'd0);
    step();
    e_run = cyc;
    chk("reen_run", 32'(running), 32'd1);
    chk("reen_lvl", 32'(level), 32'd2);
    repeat (99) step();
    chk("reen_pre_tick", 32'(level), 32'd2);
    step();
    chk("reen_tick", 32'(level), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
